// File: rtl/pv2000_cart_loader.sv
// pv2000_cart_loader
//   Sequenced owner of the 64 KiB main RAM write port for BIOS/cartridge
//   downloads (hps_io ioctl stream) and the cart-RAM erase sweep. Every load
//   or erase is followed by a stretched console reset.
//
// Ports
//   clk, reset         system clock, async active-high reset
//   ioctl_download     download window active
//   ioctl_index        0 = BIOS at 0x0000, else cartridge at CART_BASE
//   ioctl_wr           one-cycle byte strobe
//   ioctl_addr/dout    byte offset / byte data
//   erase_req          level; rising edge requests an erase
//   mem_a/mem_d/mem_we memory write port (valid while mem_own)
//   mem_own            loader owns the memory port
//   cpu_reset          console reset request
//   cart_size          bytes accepted by the last cart load (saturates at CART_MAX)
//   busy               load or erase in progress
module pv2000_cart_loader #(
  parameter int          HOLD_CYCLES = 255,
  parameter logic [15:0] CART_BASE   = 16'hC000,
  parameter logic [15:0] CART_MAX    = 16'h4000,
  parameter logic [15:0] ERASE_LO    = 16'h7000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        erase_req,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  output logic        mem_own,
  output logic        cpu_reset,
  output logic [15:0] cart_size,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ERASE_W, S_ERASE_N, S_HOLD
  } state_t;

  state_t      state, nxt;
  logic [15:0] erase_addr;
  logic [15:0] hold_cnt;
  logic        erase_prev;
  logic        erase_we_q;
  logic        own_q, busy_q, cpu_reset_q;

  logic        is_cart, in_range, erase_rise, load_we;
  logic [15:0] load_a, load_size;

  assign is_cart    = |ioctl_index;
  assign in_range   = ioctl_addr < {9'd0, CART_MAX};
  assign erase_rise = erase_req & ~erase_prev;
  assign load_a     = is_cart ? ioctl_addr[15:0] + CART_BASE : ioctl_addr[15:0];
  assign load_size  = ioctl_addr[15:0] + 16'd1;
  // Load writes pass straight through so the ioctl strobe lands the same cycle.
  assign load_we    = (state == S_LOAD) && ioctl_wr && (!is_cart || in_range);

  assign mem_we    = load_we | erase_we_q;
  assign mem_a     = (state == S_LOAD) ? load_a : (own_q ? erase_addr : 16'd0);
  assign mem_d     = (state == S_LOAD) ? ioctl_dout : 8'd0;
  assign mem_own   = own_q;
  assign busy      = busy_q;
  assign cpu_reset = cpu_reset_q;

  // Download always has priority: it pre-empts an erase or a hold, and
  // erase edges outside IDLE are dropped rather than queued.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (ioctl_download) nxt = S_LOAD;
                 else if (erase_rise) nxt = S_ERASE_W;
      S_LOAD:    if (!ioctl_download) nxt = S_HOLD;
      S_ERASE_W: nxt = ioctl_download ? S_LOAD : S_ERASE_N;
      S_ERASE_N: if (ioctl_download) nxt = S_LOAD;
                 else if (erase_addr == 16'hFFFF) nxt = S_HOLD;
                 else nxt = S_ERASE_W;
      S_HOLD:    if (ioctl_download) nxt = S_LOAD;
                 else if (hold_cnt == 16'd0) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      erase_addr  <= ERASE_LO;
      hold_cnt    <= 16'd0;
      erase_prev  <= 1'b0;
      erase_we_q  <= 1'b0;
      own_q       <= 1'b0;
      busy_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
      cart_size   <= 16'd0;
    end else begin
      state       <= nxt;
      erase_prev  <= erase_req;
      // Outputs are decoded from the next state so they track the state register.
      own_q       <= (nxt == S_LOAD) || (nxt == S_ERASE_W) || (nxt == S_ERASE_N);
      busy_q      <= (nxt == S_LOAD) || (nxt == S_ERASE_W) || (nxt == S_ERASE_N);
      cpu_reset_q <= (nxt != S_IDLE);
      erase_we_q  <= (nxt == S_ERASE_W);

      if (state == S_IDLE && nxt == S_ERASE_W)
        erase_addr <= ERASE_LO;
      else if (state == S_ERASE_N && nxt == S_ERASE_W)
        erase_addr <= erase_addr + 16'd1;

      // HOLD spans HOLD_CYCLES+1 cycles: the count runs HOLD_CYCLES..0.
      if (nxt == S_HOLD && state != S_HOLD)
        hold_cnt <= 16'(HOLD_CYCLES);
      else if (state == S_HOLD && hold_cnt != 16'd0)
        hold_cnt <= hold_cnt - 16'd1;

      // A fresh cart image restarts the size; dropped bytes never grow it.
      if (nxt == S_LOAD && state != S_LOAD && is_cart)
        cart_size <= 16'd0;
      else if (load_we && is_cart && load_size > cart_size)
        cart_size <= load_size;
    end
  end

endmodule

// File: tb/tb_pv2000_cart_loader.sv
module tb_pv2000_cart_loader;

  localparam int HOLD = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        erase_req;
  logic [15:0] mem_a;
  logic [7:0]  mem_d;
  logic        mem_we;
  logic        mem_own;
  logic        cpu_reset;
  logic [15:0] cart_size;
  logic        busy;

  pv2000_cart_loader #(
    .HOLD_CYCLES(HOLD), .CART_BASE(16'hC000), .CART_MAX(16'h4000), .ERASE_LO(16'h7000)
  ) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .erase_req(erase_req),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_own(mem_own),
    .cpu_reset(cpu_reset), .cart_size(cart_size), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          gap;   // required cycles since previous write, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   last_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got a=%h d=%h, required no write", mem_a, mem_d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_a !== e.a || mem_d !== e.d || mem_own !== 1'b1) begin
          errors++;
          $display("FAIL write: got a=%h d=%h own=%b, required a=%h d=%h own=1",
                   mem_a, mem_d, mem_own, e.a, e.d);
        end else if (e.gap != 0 && (cyc - last_wr) != e.gap) begin
          errors++;
          $display("FAIL write_gap at %h: got %0d cycles, required %0d", e.a, cyc - last_wr, e.gap);
        end
      end
      last_wr = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the strobe lives for exactly one cycle.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                         input logic exp_we, input logic [15:0] exp_a);
    if (exp_we) sb.push_back('{exp_a, d, 0});
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    chk("we_same_cycle", {31'd0, mem_we}, {31'd0, exp_we});
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Counts busy and busy-free reset cycles until cpu_reset drops.
  task automatic measure(output int busy_n, output int hold_n);
    busy_n = 0;
    hold_n = 0;
    for (int i = 0; i < 'h14000; i++) begin
      @(negedge clk);
      if (!cpu_reset) break;
      if (busy) busy_n++;
      else hold_n++;
    end
    chk("op_end_timeout", {31'd0, cpu_reset}, 32'd0);
    tick();
  endtask

  task automatic push_erase(input int lo, input int hi);
    for (int a = lo; a <= hi; a++)
      sb.push_back('{a[15:0], 8'h00, (a == lo) ? 0 : 2});
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, hn, k;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; erase_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we",   {31'd0, mem_we},    32'd0);
    chk("rst_own",  {31'd0, mem_own},   32'd0);
    chk("rst_creset", {31'd0, cpu_reset}, 32'd0);
    chk("rst_busy", {31'd0, busy},      32'd0);
    chk("rst_cart", {16'd0, cart_size}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // BIOS load
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    tick();
    chk("bios_busy",   {31'd0, busy},      32'd1);
    chk("bios_own",    {31'd0, mem_own},   32'd1);
    chk("bios_creset", {31'd0, cpu_reset}, 32'd1);
    wr_byte(25'h0123, 8'h55, 1'b1, 16'h0123);
    wr_byte(25'hFFFF, 8'h5A, 1'b1, 16'hFFFF);
    chk("bios_cart_size", {16'd0, cart_size}, 32'd0);
    ioctl_download = 1'b0;
    measure(bn, hn);
    chk("bios_hold_len", hn, HOLD + 1);
    // strobe outside LOAD produces nothing
    wr_byte(25'h0010, 8'h77, 1'b0, 16'h0000);

    // Cart load with clipping
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    tick();
    chk("cart_clear", {16'd0, cart_size}, 32'd0);
    wr_byte(25'h0000, 8'hA1, 1'b1, 16'hC000);
    chk("cart_size_1", {16'd0, cart_size}, 32'h1);
    wr_byte(25'h0001, 8'hA2, 1'b1, 16'hC001);
    wr_byte(25'h3FFF, 8'hA3, 1'b1, 16'hFFFF);
    chk("cart_size_max", {16'd0, cart_size}, 32'h4000);
    wr_byte(25'h4000, 8'hA4, 1'b0, 16'h0000);
    wr_byte(25'h4001, 8'hA5, 1'b0, 16'h0000);
    wr_byte(25'h1000000, 8'hA6, 1'b0, 16'h0000);
    wr_byte(25'h0005, 8'hA7, 1'b1, 16'hC005);
    chk("cart_size_clip", {16'd0, cart_size}, 32'h4000);
    ioctl_download = 1'b0;
    measure(bn, hn);

    // Small cart
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    tick();
    chk("small_clear", {16'd0, cart_size}, 32'd0);
    wr_byte(25'h0000, 8'h01, 1'b1, 16'hC000);
    wr_byte(25'h1FFF, 8'h02, 1'b1, 16'hDFFF);
    wr_byte(25'h0100, 8'h03, 1'b1, 16'hC100);
    chk("small_size", {16'd0, cart_size}, 32'h2000);
    ioctl_download = 1'b0;
    measure(bn, hn);
    chk("cart_hold_len", hn, HOLD + 1);

    // Full erase
    push_erase('h7000, 'hFFFF);
    erase_req = 1'b1;
    tick();
    chk("erase_first_we", {31'd0, mem_we}, 32'd1);
    chk("erase_first_a",  {16'd0, mem_a},  32'h7000);
    measure(bn, hn);
    chk("erase_cycles", bn, 'h12000);
    chk("erase_hold_len", hn, HOLD + 1);
    chk("erase_all_done", sb.size(), 0);
    repeat (4) tick();
    chk("erase_level_no_retrig", {31'd0, busy}, 32'd0);

    // Abort erase at 0x8000 with a download
    erase_req = 1'b0;
    tick();
    push_erase('h7000, 'h8000);
    erase_req = 1'b1;
    k = 0;
    while (!(mem_we && mem_a == 16'h8000) && k < 'h3000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_8000", {16'd0, mem_a}, 32'h8000);
    tick();
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    tick();
    chk("abort_load_busy", {31'd0, busy}, 32'd1);
    chk("abort_no_we",     {31'd0, mem_we}, 32'd0);
    chk("abort_load_a",    {16'd0, mem_a}, {7'd0, ioctl_addr});
    repeat (10) tick();
    ioctl_download = 1'b0;
    measure(bn, hn);
    repeat (10) tick();
    chk("abort_no_new_erase", {31'd0, busy}, 32'd0);
    chk("abort_sb_empty", sb.size(), 0);

    // Async reset mid-erase
    erase_req = 1'b0;
    tick();
    push_erase('h7000, 'h7009);
    erase_req = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rst_erase_progress", sb.size(), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we",    {31'd0, mem_we},    32'd0);
    chk("arst_own",   {31'd0, mem_own},   32'd0);
    chk("arst_creset", {31'd0, cpu_reset}, 32'd0);
    chk("arst_busy",  {31'd0, busy},      32'd0);
    chk("arst_cart",  {16'd0, cart_size}, 32'd0);
    erase_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_idle", {31'd0, busy | cpu_reset}, 32'd0);
    erase_req = 1'b1;
    tick();
    chk("new_edge_erases", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    erase_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
